// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency memory between fetch,
// load and store. Fixed priority with fetch anti-starvation and an access watchdog.
module mem_arbiter #(
    parameter int unsigned W       = 32,
    parameter int unsigned STARVE  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_req,
    input  logic [W-1:0] i_addr,
    output logic [W-1:0] i_rdata,
    output logic         i_done,
    input  logic         l_req,
    input  logic [W-1:0] l_addr,
    output logic [W-1:0] l_rdata,
    output logic         l_done,
    input  logic         s_req,
    input  logic [W-1:0] s_addr,
    input  logic [W-1:0] s_data,
    output logic         s_done,
    output logic         err,
    output logic         stall,
    output logic         mem_req,
    output logic         mem_we,
    output logic [W-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [W-1:0] mem_rdata
);
    localparam int unsigned SW = 4;
    localparam int unsigned TW = 8;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE);
    localparam logic [TW-1:0] WD_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_I = 2'd0,
        OWN_L = 2'd1,
        OWN_S = 2'd2
    } owner_t;

    state_t          state;
    owner_t          owner;
    logic [SW-1:0]   starve_cnt;
    logic [TW-1:0]   wd_cnt;

    logic            i_pend;
    logic            l_pend;
    logic            s_pend;
    logic            win_valid;
    owner_t          win;
    logic [W-1:0]    win_addr;
    logic            ack;
    logic            finish;
    logic [W-1:0]    fill;

    // Masked requests and winner selection; a starved fetch overrides priority.
    always_comb begin
        i_pend    = i_req & ~i_done;
        l_pend    = l_req & ~l_done;
        s_pend    = s_req & ~s_done;
        win_valid = i_pend | l_pend | s_pend;
        win       = OWN_I;
        if (i_pend && (starve_cnt == STARVE_LIM)) begin
            win = OWN_I;
        end else if (s_pend) begin
            win = OWN_S;
        end else if (l_pend) begin
            win = OWN_L;
        end
        case (win)
            OWN_S:   win_addr = s_addr;
            OWN_L:   win_addr = l_addr;
            default: win_addr = i_addr;
        endcase
    end

    assign ack    = mem_ack & mem_req;
    assign finish = ack | (wd_cnt == WD_LAST);
    // An aborted access returns zero to its owner.
    assign fill   = ack ? mem_rdata : '0;

    assign stall = (i_req & ~i_done) | (l_req & ~l_done) | (s_req & ~s_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            starve_cnt <= '0;
            wd_cnt     <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            i_rdata    <= '0;
            l_rdata    <= '0;
            i_done     <= 1'b0;
            l_done     <= 1'b0;
            s_done     <= 1'b0;
            err        <= 1'b0;
        end else begin
            i_done <= 1'b0;
            l_done <= 1'b0;
            s_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        owner     <= win;
                        mem_req   <= 1'b1;
                        mem_we    <= (win == OWN_S);
                        mem_addr  <= win_addr;
                        mem_wdata <= (win == OWN_S) ? s_data : '0;
                        wd_cnt    <= '0;
                        state     <= BUSY;
                        // Count data grants that bypass a waiting fetch.
                        if ((win == OWN_I) || !i_pend) begin
                            starve_cnt <= '0;
                        end else if (starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + SW'(1);
                        end
                    end
                end
                BUSY: begin
                    if (finish) begin
                        mem_req <= 1'b0;
                        err     <= ~ack;
                        state   <= DONE;
                        case (owner)
                            OWN_I: begin
                                i_done  <= 1'b1;
                                i_rdata <= fill;
                            end
                            OWN_L: begin
                                l_done  <= 1'b1;
                                l_rdata <= fill;
                            end
                            default: s_done <= 1'b1;
                        endcase
                    end else begin
                        wd_cnt <= wd_cnt + TW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table vectors, hand-written corner sequences and a random run
// checked against a transaction-level schedule model of the arbiter.
module tb_mem_arbiter;
    localparam int STARVE  = 4;
    localparam int TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic        i_req, l_req, s_req;
    logic [31:0] i_addr, l_addr, s_addr, s_data;
    logic [31:0] i_rdata, l_rdata;
    logic        i_done, l_done, s_done, err, stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_arbiter #(.W(32), .STARVE(STARVE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
        .l_req(l_req), .l_addr(l_addr), .l_rdata(l_rdata), .l_done(l_done),
        .s_req(s_req), .s_addr(s_addr), .s_data(s_data), .s_done(s_done),
        .err(err), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // memory / stimulus configuration
    int          cfg_lat = 1;      // -1: random per access, 0: never ack
    bit          cfg_fixed = 0;
    logic [31:0] cfg_data = '0;
    bit          noise_en = 0;
    bit          auto_release = 1;

    // reference schedule: an access granted at edge g with k memory cycles holds
    // mem_req for cycles g..g+k-1, signals done in cycle g+k, next grant at g+k+2
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_g = 0, m_k = 0, m_own = 0, m_starve = 0, free_edge = 0;
    bit          m_abort = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0;
    logic [31:0] e_irdata = '0, e_lrdata = '0;
    bit          e_di, e_dl, e_ds, e_err, e_mreq;
    int          done_log[$];

    typedef struct packed {
        logic [2:0] reqs;       // {s, l, i}
        int         lat;
        int         first;      // 0 fetch, 1 load, 2 store
        logic       we;
        int         lat_steps;
        logic       err;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 0;
        if (r == 1) return TIMEOUT;
        if (r == 2) return TIMEOUT + 3;
        return int'($urandom_range(1, 4));
    endfunction

    task automatic model_update();
        int w;
        int lat;
        e_di = 0; e_dl = 0; e_ds = 0; e_err = 0;
        if (rst) begin
            m_busy = 0; m_starve = 0; e_irdata = '0; e_lrdata = '0; free_edge = cyc + 1;
        end else if (m_busy && cyc == m_g + m_k) begin
            m_busy = 0; free_edge = cyc + 2; e_err = m_abort;
            if (m_own == 0) begin e_di = 1; e_irdata = m_abort ? 32'h0 : m_data; end
            else if (m_own == 1) begin e_dl = 1; e_lrdata = m_abort ? 32'h0 : m_data; end
            else e_ds = 1;
        end else if (!m_busy && cyc >= free_edge && (i_req || l_req || s_req)) begin
            if (i_req && m_starve == STARVE) w = 0;
            else if (s_req) w = 2;
            else if (l_req) w = 1;
            else w = 0;
            if (w == 0 || !i_req) m_starve = 0;
            else if (m_starve < STARVE) m_starve++;
            lat     = (cfg_lat >= 0) ? cfg_lat : pick_lat();
            m_abort = (lat == 0) || (lat > TIMEOUT);
            m_k     = m_abort ? TIMEOUT : lat;
            m_busy  = 1; m_g = cyc; m_own = w;
            m_addr  = (w == 2) ? s_addr : (w == 1) ? l_addr : i_addr;
            m_wdata = s_data;
            m_data  = cfg_fixed ? cfg_data : $urandom;
        end
        e_mreq = m_busy;
    endtask

    task automatic model_check();
        chk("mem_req", {31'h0, mem_req}, {31'h0, e_mreq});
        chk("i_done", {31'h0, i_done}, {31'h0, e_di});
        chk("l_done", {31'h0, l_done}, {31'h0, e_dl});
        chk("s_done", {31'h0, s_done}, {31'h0, e_ds});
        chk("err", {31'h0, err}, {31'h0, e_err});
        chk("i_rdata", i_rdata, e_irdata);
        chk("l_rdata", l_rdata, e_lrdata);
        chk("stall", {31'h0, stall},
            {31'h0, (i_req & ~e_di) | (l_req & ~e_dl) | (s_req & ~e_ds)});
        if (e_mreq) begin
            chk("mem_we", {31'h0, mem_we}, {31'h0, m_own == 2});
            chk("mem_addr", mem_addr, m_addr);
            if (m_own == 2) chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (rst) begin
            chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
        end
    endtask

    task automatic drive_memory();
        if (m_busy && !m_abort && cyc == m_g + m_k - 1) begin
            mem_ack = 1'b1; mem_rdata = m_data;
        end else begin
            mem_ack   = (!m_busy && noise_en) ? ($urandom_range(0, 3) == 0) : 1'b0;
            mem_rdata = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        model_update();
        model_check();
        if (i_done) done_log.push_back(0);
        if (l_done) done_log.push_back(1);
        if (s_done) done_log.push_back(2);
        drive_memory();
        if (auto_release) begin
            if (i_done) i_req = 1'b0;
            if (l_done) l_req = 1'b0;
            if (s_done) s_req = 1'b0;
        end
    endtask

    task automatic do_reset();
        i_req = 0; l_req = 0; s_req = 0; rst = 1;
        step(); step();
        rst = 0;
        done_log.delete();
    endtask

    task automatic run_until_done(input int bound, output bit got, output int n, output logic e);
        got = 0; n = 0; e = 0;
        while (!got && n < bound) begin
            step(); n++;
            if (i_done || l_done || s_done) begin got = 1; e = err; end
        end
        chk("done_within_bound", {31'h0, got}, 32'h1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while ((i_req || l_req || s_req) && n < bound) begin step(); n++; end
        chk("drain_within_bound", {31'h0, i_req | l_req | s_req}, 32'h0);
        step(); step();
    endtask

    initial begin
        bit          got;
        int          n, hi, first;
        logic        e, we_seen;

        rst = 1; i_req = 0; l_req = 0; s_req = 0;
        i_addr = '0; l_addr = '0; s_addr = '0; s_data = '0;
        mem_ack = 0; mem_rdata = '0;

        tbl[0] = '{3'b001, 1, 0, 1'b0, 2, 1'b0};
        tbl[1] = '{3'b011, 1, 1, 1'b0, 2, 1'b0};
        tbl[2] = '{3'b111, 2, 2, 1'b1, 3, 1'b0};
        tbl[3] = '{3'b110, 3, 2, 1'b1, 4, 1'b0};
        tbl[4] = '{3'b010, 0, 1, 1'b0, 9, 1'b1};
        tbl[5] = '{3'b101, 8, 2, 1'b1, 9, 1'b0};
        tbl[6] = '{3'b001, 0, 0, 1'b0, 9, 1'b1};
        tbl[7] = '{3'b011, 4, 1, 1'b0, 5, 1'b0};

        // reset values
        do_reset();
        chk("reset_stall", {31'h0, stall}, 32'h0);
        chk("reset_i_rdata", i_rdata, 32'h0);

        // single zero-wait fetch
        cfg_fixed = 1; cfg_data = 32'hDEADBEEF; cfg_lat = 1;
        i_addr = 32'h100; i_req = 1;
        step();
        chk("f1_mem_req", {31'h0, mem_req}, 32'h1);
        chk("f1_mem_addr", mem_addr, 32'h100);
        step();
        chk("f2_i_done", {31'h0, i_done}, 32'h1);
        chk("f2_i_rdata", i_rdata, 32'hDEADBEEF);
        chk("f2_mem_req", {31'h0, mem_req}, 32'h0);
        step();
        chk("f3_stall", {31'h0, stall}, 32'h0);
        chk("f3_i_done", {31'h0, i_done}, 32'h0);
        cfg_fixed = 0;

        // table-driven simultaneous-request vectors
        for (int v = 0; v < 8; v++) begin
            do_reset();
            cfg_lat = tbl[v].lat;
            i_addr = $urandom; l_addr = $urandom; s_addr = $urandom; s_data = $urandom;
            i_req = tbl[v].reqs[0]; l_req = tbl[v].reqs[1]; s_req = tbl[v].reqs[2];
            got = 0; n = 0; e = 0; we_seen = 0; first = -1;
            while (!got && n < 40) begin
                step(); n++;
                if (n == 1) we_seen = mem_we;
                if (i_done || l_done || s_done) begin
                    got = 1; e = err;
                    first = s_done ? 2 : l_done ? 1 : 0;
                end
            end
            chk($sformatf("vec%0d_first", v), 32'(first), 32'(tbl[v].first));
            chk($sformatf("vec%0d_latency", v), 32'(n), 32'(tbl[v].lat_steps));
            chk($sformatf("vec%0d_we", v), {31'h0, we_seen}, {31'h0, tbl[v].we});
            chk($sformatf("vec%0d_err", v), {31'h0, e}, {31'h0, tbl[v].err});
            wait_idle(60);
        end

        // store, load, fetch with 2-cycle memory; s_data changes during BUSY
        do_reset();
        cfg_lat = 2;
        s_addr = 32'h200; s_data = 32'h5555AAAA; l_addr = 32'h300; i_addr = 32'h400;
        s_req = 1; l_req = 1; i_req = 1;
        step();
        chk("sli_we", {31'h0, mem_we}, 32'h1);
        chk("sli_wdata1", mem_wdata, 32'h5555AAAA);
        s_data = 32'h12345678;
        step();
        chk("sli_wdata2", mem_wdata, 32'h5555AAAA);
        wait_idle(60);
        chk("sli_count", 32'(done_log.size()), 32'd3);
        if (done_log.size() == 3) begin
            chk("sli_order0", 32'(done_log[0]), 32'd2);
            chk("sli_order1", 32'(done_log[1]), 32'd1);
            chk("sli_order2", 32'(done_log[2]), 32'd0);
        end

        // continuous data requests with fetch held: fetch every STARVE+1 grants
        do_reset();
        cfg_lat = 1; auto_release = 0;
        s_req = 1; l_req = 1; i_req = 1;
        n = 0;
        while (done_log.size() < 2 * (STARVE + 1) && n < 200) begin step(); n++; end
        chk("starve_count", 32'(done_log.size()), 32'(2 * (STARVE + 1)));
        for (int k = 0; k < done_log.size() && k < 2 * (STARVE + 1); k++)
            chk($sformatf("starve_grant%0d", k), 32'(done_log[k]),
                ((k + 1) % (STARVE + 1) == 0) ? 32'd0 : 32'd2);
        auto_release = 1; s_req = 0; l_req = 0; i_req = 0;
        step(); step(); step();

        // watchdog abort then normal recovery
        do_reset();
        cfg_fixed = 1; cfg_data = 32'hCAFEF00D; cfg_lat = 1;
        l_addr = 32'h40; l_req = 1;
        run_until_done(10, got, n, e);
        chk("to_pre_rdata", l_rdata, 32'hCAFEF00D);
        step();
        cfg_lat = 0; l_req = 1;
        got = 0; n = 0; hi = 0;
        while (!got && n < 30) begin
            step(); n++;
            if (mem_req) hi++;
            if (l_done) begin
                got = 1;
                chk("to_err", {31'h0, err}, 32'h1);
                chk("to_rdata", l_rdata, 32'h0);
            end
        end
        chk("to_done", {31'h0, got}, 32'h1);
        chk("to_req_cycles", 32'(hi), 32'(TIMEOUT));
        step();
        chk("to_err_cleared", {31'h0, err}, 32'h0);
        cfg_lat = 1; cfg_data = 32'h0BADC0DE; l_req = 1;
        run_until_done(10, got, n, e);
        chk("to_after_err", {31'h0, e}, 32'h0);
        chk("to_after_rdata", l_rdata, 32'h0BADC0DE);
        chk("to_after_latency", 32'(n), 32'd2);
        step();

        // reset in the second BUSY cycle of a store
        cfg_lat = 0; s_addr = 32'h80; s_data = 32'h77; s_req = 1;
        n = 0;
        do begin step(); n++; end while (!mem_req && n < 10);
        step();
        chk("rb_busy2", {31'h0, mem_req}, 32'h1);
        rst = 1;
        step();
        chk("rb_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rb_s_done", {31'h0, s_done}, 32'h0);
        chk("rb_l_rdata", l_rdata, 32'h0);
        rst = 0; cfg_lat = 1;
        run_until_done(10, got, n, e);
        chk("rb_redo_s_done", {31'h0, s_done}, 32'h1);
        chk("rb_redo_latency", 32'(n), 32'd2);
        step();

        // randomized traffic
        cfg_fixed = 0; cfg_lat = -1; noise_en = 1;
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 499) == 0);
            if (!i_req) begin
                if ($urandom_range(0, 5) == 0) begin i_req = 1; i_addr = $urandom; end
            end else if ($urandom_range(0, 15) == 0) i_addr = $urandom;
            else if ($urandom_range(0, 79) == 0) i_req = 0;
            if (!l_req) begin
                if ($urandom_range(0, 5) == 0) begin l_req = 1; l_addr = $urandom; end
            end else if ($urandom_range(0, 15) == 0) l_addr = $urandom;
            else if ($urandom_range(0, 79) == 0) l_req = 0;
            if (!s_req) begin
                if ($urandom_range(0, 5) == 0) begin
                    s_req = 1; s_addr = $urandom; s_data = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                s_addr = $urandom; s_data = $urandom;
            end else if ($urandom_range(0, 79) == 0) s_req = 0;
        end
        rst = 0; i_req = 0; l_req = 0; s_req = 0; noise_en = 0;
        for (int c = 0; c < 20; c++) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Three-requester arbiter that shares one single-ported, variable-latency memory between instruction fetch, data load and data store of the multicycle core. It sits between the core's fetch, load and store ports and the external memory. It serialises accesses with a req/done handshake and drives a stall for the stage counter. Fixed priority is tempered by an anti-starvation counter for fetch, and a watchdog bounds every memory access.

## Interface
- W, 32, data/address width
- STARVE, 4, consecutive data grants allowed while fetch waits before fetch is forced (1..15)
- TIMEOUT, 255, max cycles waiting for mem_ack before abort (1..255)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, level, held until i_done
- i_addr  in  W  fetch address
- i_rdata  out  W  fetch data, registered
- i_done  out  1  one-cycle completion pulse for fetch
- l_req / l_addr  in  1 / W  load request and address
- l_rdata  out  W  load data, registered
- l_done  out  1  load completion pulse
- s_req / s_addr / s_data  in  1 / W / W  store request, address, data
- s_done  out  1  store completion pulse
- err  out  1  pulses with the done of an access aborted by timeout
- stall  out  1  combinational: (i_req&~i_done)|(l_req&~l_done)|(s_req&~s_done)
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write
- mem_addr / mem_wdata  out  W  registered address and write data
- mem_ack  in  1  memory completion, sampled only while mem_req=1
- mem_rdata  in  W  valid when mem_ack=1 and mem_we=0

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: form masked requests by clearing any req whose done is high this cycle. If none remain, stay in IDLE.
  - Winner priority: store > load > fetch.
  - Exception: if starve_cnt == STARVE and i_req is pending, fetch wins.
  - On a winner: latch addr, wdata and the owner id into mem_* registers, set mem_we (1 only for store) and mem_req=1, clear wd_cnt, go to BUSY.
- starve_cnt (4 bit):
  - Increments on each data grant made while i_req is pending.
  - Clears on a fetch grant, and clears when i_req is low at a grant.
  - Saturates at STARVE.
- BUSY: mem_req held at 1; mem_addr, mem_wdata and mem_we stay stable.
  - mem_ack=1: capture mem_rdata into the owner's rdata register (load/fetch only), drop mem_req, go to DONE.
  - Otherwise wd_cnt increments. If wd_cnt == TIMEOUT-1 and still no ack: drop mem_req, write 0 into the owner's rdata, set the abort flag, go to DONE.
- DONE: the owner's done is high for exactly one cycle; err=1 if aborted. Next state is IDLE.
- Requesters' addr/data may change after grant without effect, since values are latched.
- A req deasserted before its done still completes. The done pulse is still issued and may be ignored.
- rdata registers hold their value until overwritten by the next access of the same requester.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, all rdata=0, all done=0, err=0, state=IDLE, starve_cnt=0, wd_cnt=0.
- rst is sampled on any edge, including mid-BUSY. mem_req is 0 the cycle after, and no done is issued for the killed access.
- Minimum latency with zero-wait memory (mem_ack high in the first BUSY cycle):
  - req sampled at edge 0, mem_req high in cycle 1.
  - ack sampled at edge 1, done and rdata valid in cycle 2.
  - Total: 2 cycles req to done.
- A memory that acks after k BUSY cycles gives latency 1+k+1.
- Throughput is one access per 3 cycles with zero-wait memory: IDLE, BUSY, DONE.
- A new grant can be made in the IDLE cycle immediately after DONE. The just-finished requester is masked only in its done cycle.
- Abort: mem_req is high for exactly TIMEOUT cycles, then DONE with err=1.
- mem_ack while mem_req=0 is ignored.

## Test plan
- Reset then single fetch, i_addr=0x100, zero-wait memory returning 0xDEADBEEF:
  - Required: mem_req high in cycle 1 only, i_done and i_rdata=0xDEADBEEF in cycle 2, stall low in cycle 3.
- Load and fetch asserted together:
  - Required: load served first, then fetch. No grant to load in the cycle l_done is high.
- Store, load and fetch all pending with 2-cycle memory:
  - Required order is store, load, fetch.
  - mem_we=1 only for the store, with mem_wdata equal to s_data captured at grant even if s_data changes during BUSY.
- Continuous l_req and s_req with i_req held, STARVE=4:
  - Required: fetch is granted after exactly 4 data grants, and starve_cnt is 0 afterwards.
- mem_ack never asserted, TIMEOUT=8:
  - Required: mem_req high for 8 cycles, then l_done=1 and err=1 for one cycle, l_rdata=0, and the next request proceeds normally.
- rst asserted in the 2nd BUSY cycle of a store:
  - Required: mem_req=0 and all outputs at reset values the next cycle, no s_done.
  - Store re-requested after reset completes normally.
